// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiply sequencer: sizes, FSM states, element indexing.
package mat_pkg;

    localparam int unsigned MAT_N  = 4;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned MAT_W  = 256;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_LD_A,
        S_WT_A,
        S_RD_B,
        S_LD_B,
        S_WT_R,
        S_WR,
        S_DONE
    } seq_state_t;

    // Row-major element [i][j] starts at this bit of a matrix word.
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
        return i * MAT_N * ELEM_W + ELEM_W * j;
    endfunction

endpackage

// File: rtl/mat_seq_timeout.sv
// Per-state watchdog: reloads on every state change, counts down while enabled,
// and flags expiry on the TIMEOUT-th enabled cycle in the same state.
module mat_seq_timeout #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/mat_mult_sequencer.sv
// Command sequencer: reads operands A and B, feeds them to the 4x4 multiplier, writes the product back.
// Define MAT_SEQ_PERF_EN to add the perf_cycles / perf_cmds counters.
module mat_mult_sequencer
    import mat_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned DATA_W  = MAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mult_en,
    output logic              mult_rw,
    output logic [DATA_W-1:0] mult_data,
    input  logic [DATA_W-1:0] mult_result,
    input  logic              mult_flag,
`ifdef MAT_SEQ_PERF_EN
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_cmds,
`endif
    output logic              busy,
    output logic              done,
    output logic              err
);

    seq_state_t        state, state_nx;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0] op_a, op_b, res;
    logic              flag_q, fall_seen, rise;
    logic              abort, tmo_en, expire;

    assign tmo_en = (state == S_RD_A) || (state == S_WT_A) || (state == S_RD_B) ||
                    (state == S_WT_R) || (state == S_WR);

    // Product is ready only on a rising flag that follows a fall seen in WT_R.
    assign rise = fall_seen && !flag_q && mult_flag;

    mat_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_nx != state),
        .en     (tmo_en),
        .expire (expire)
    );

    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) state_nx = S_RD_A;
            S_RD_A: if (mem_ack) state_nx = S_LD_A; else if (expire) abort = 1'b1;
            S_LD_A: state_nx = S_WT_A;
            S_WT_A: if (mult_flag) state_nx = S_RD_B; else if (expire) abort = 1'b1;
            S_RD_B: if (mem_ack) state_nx = S_LD_B; else if (expire) abort = 1'b1;
            S_LD_B: state_nx = S_WT_R;
            S_WT_R: if (rise) state_nx = S_WR; else if (expire) abort = 1'b1;
            S_WR:   if (mem_ack) state_nx = S_DONE; else if (expire) abort = 1'b1;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res       <= '0;
            flag_q    <= 1'b0;
            fall_seen <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_nx;
            err    <= abort;
            flag_q <= mult_flag;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    src_a_q <= cmd_src_a;
                    src_b_q <= cmd_src_b;
                    dst_q   <= cmd_dst;
                end
                S_RD_A: if (mem_ack) op_a <= mem_rdata;
                S_RD_B: if (mem_ack) op_b <= mem_rdata;
                S_WT_R: begin
                    if (rise) res <= mult_result;
                    if (state_nx != S_WT_R) fall_seen <= 1'b0;
                    else if (flag_q && !mult_flag) fall_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign mem_req   = (state == S_RD_A) || (state == S_RD_B) || (state == S_WR);
    assign mem_we    = (state == S_WR);
    assign mem_wdata = (state == S_WR) ? res : '0;
    assign mult_en   = (state == S_LD_A) || (state == S_LD_B);
    assign mult_rw   = mult_en;

    always_comb begin
        mem_addr  = '0;
        mult_data = '0;
        case (state)
            S_RD_A: mem_addr = src_a_q;
            S_RD_B: mem_addr = src_b_q;
            S_WR:   mem_addr = dst_q;
            S_LD_A: mult_data = op_a;
            S_LD_B: mult_data = op_b;
            default: ;
        endcase
    end

`ifdef MAT_SEQ_PERF_EN
    logic [31:0] busy_cnt;

    // busy_cnt holds the cycles already spent; the DONE cycle itself is added on latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt    <= '0;
            perf_cycles <= '0;
            perf_cmds   <= '0;
        end else begin
            busy_cnt <= (state == S_IDLE) ? '0 : busy_cnt + 32'd1;
            if (state == S_DONE) begin
                perf_cycles <= busy_cnt + 32'd1;
                perf_cmds   <= perf_cmds + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mat_mult_sequencer.sv
// Self-checking bench for mat_mult_sequencer with behavioural memory and multiplier models.
module tb_mat_mult_sequencer;
    import mat_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;
    localparam int DATA_W  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;
    logic              mult_en, mult_rw;
    logic [DATA_W-1:0] mult_data;
    logic [DATA_W-1:0] mult_result = '0;
    logic              mult_flag = 1'b0;
    logic              busy, done, err;
`ifdef MAT_SEQ_PERF_EN
    logic [31:0]       perf_cycles;
    logic [15:0]       perf_cmds;
`endif

    always #5 clk = ~clk;

    mat_mult_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mult_en(mult_en), .mult_rw(mult_rw), .mult_data(mult_data),
        .mult_result(mult_result), .mult_flag(mult_flag),
`ifdef MAT_SEQ_PERF_EN
        .perf_cycles(perf_cycles), .perf_cmds(perf_cmds),
`endif
        .busy(busy), .done(done), .err(err)
    );

    int          checks = 0;
    int          passed = 0;
    int          n_ok = 0;
    int          mem_delay = 0;
    bit          mult_stall = 1'b0;
    logic [255:0] mem [256];
    logic [7:0]  wr_addr_q [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference 4x4 product, elements modulo 2^16.
    function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] c;
        logic [15:0]  s;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = '0;
                for (int k = 0; k < 4; k++)
                    s = s + a[elem_lsb(i, k) +: 16] * b[elem_lsb(k, j) +: 16];
                c[elem_lsb(i, j) +: 16] = s;
            end
        return c;
    endfunction

    // Memory: acks after mem_delay extra request cycles; reads/writes happen in the ack cycle.
    initial begin
        int cnt;
        bit prev_ack;
        cnt = 0;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ack) chk("req_drop_after_ack", 256'(mem_req), '0);
            prev_ack = 1'b0;
            mem_ack = 1'b0;
            mem_rdata = rnd256();
            if (!rst_n || !mem_req) cnt = 0;
            else if (cnt >= mem_delay) begin
                mem_ack = 1'b1;
                prev_ack = 1'b1;
                cnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_addr_q.push_back(mem_addr);
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else cnt++;
        end
    end

    // Multiplier: flag high one cycle after operand A; after operand B the flag
    // drops for one cycle and rises again with the product (unless stalled).
    initial begin
        int nops, pb;
        bit pa, prev_en;
        logic [255:0] oa, ob;
        nops = 0; pb = 0; pa = 1'b0; prev_en = 1'b0; oa = '0; ob = '0;
        forever begin
            @(negedge clk);
            mult_result = rnd256();
            if (!rst_n) begin
                nops = 0; pb = 0; pa = 1'b0; prev_en = 1'b0; mult_flag = 1'b0;
            end else begin
                if (pb == 2) begin
                    mult_result = matmul(oa, ob);
                    mult_flag = 1'b1;
                    pb = 0;
                end else if (pb == 1) begin
                    mult_flag = 1'b0;
                    pb = mult_stall ? 0 : 2;
                end
                if (pa) begin
                    mult_flag = 1'b1;
                    pa = 1'b0;
                end
                if (mult_en) begin
                    chk("mult_rw", 256'(mult_rw), 256'(1));
                    chk("mult_en_gap", 256'(prev_en), '0);
                    if (nops == 0) begin oa = mult_data; pa = 1'b1; nops = 1; end
                    else begin ob = mult_data; pb = 1; nops = 0; end
                end
                prev_en = mult_en;
            end
        end
    end

    // lat = cycles from the first busy cycle to the done (or err) cycle.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                           input int delay, output int lat, output bit gd, output bit ge);
        int n;
        mem_delay = delay;
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!done && !err && n < 300) begin
            @(negedge clk);
            n++;
        end
        gd = done; ge = err; lat = n;
    endtask

    task automatic check_cmd(input string nm, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] d, input int delay, input logic [255:0] exp);
        int lat, wq0;
        bit gd, ge;
        wq0 = wr_addr_q.size();
        run_cmd(a, b, d, delay, lat, gd, ge);
        chk({nm, "_done"}, 256'(gd), 256'(1));
        chk({nm, "_err"}, 256'(ge), '0);
        chk({nm, "_latency"}, 256'(lat), 256'(8 + 3 * delay));
        chk({nm, "_result"}, mem[d], exp);
        chk({nm, "_writes"}, 256'(wr_addr_q.size() - wq0), 256'(1));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 256'(done), '0);
        chk({nm, "_ready"}, 256'(cmd_ready), 256'(1));
`ifdef MAT_SEQ_PERF_EN
        n_ok++;
        chk({nm, "_perf_cycles"}, 256'(perf_cycles), 256'(lat + 1));
        chk({nm, "_perf_cmds"}, 256'(perf_cmds), 256'(n_ok));
`endif
    endtask

    typedef struct {
        logic [7:0]   a, b, d;
        int           delay;
        logic [255:0] ma, mb, exp;
    } vec_t;

    initial begin
        vec_t tbl [4];
        logic [255:0] ident, bmat, all2, all3, e1, e2;
        logic [7:0] a, b, d;
        int lat, wq0, n;
        bit gd, ge, bad;

        ident = '0;
        bmat = '0;
        for (int i = 0; i < 4; i++) begin
            ident[elem_lsb(i, i) +: 16] = 16'h0001;
            for (int j = 0; j < 4; j++) bmat[elem_lsb(i, j) +: 16] = 16'(i * 4 + j + 1);
        end
        all2 = {16{16'h0002}};
        all3 = {16{16'h0003}};
        tbl[0] = '{8'h01, 8'h02, 8'h03, 0, ident, bmat, bmat};
        tbl[1] = '{8'h10, 8'h11, 8'h12, 0, all2, all3, {16{16'h0018}}};
        tbl[2] = '{8'h20, 8'h21, 8'h22, 2, all3, all2, {16{16'h0018}}};
        tbl[3] = '{8'h30, 8'h30, 8'h30, 1, all2, all2, {16{16'h0010}}};
        for (int i = 0; i < 256; i++) mem[i] = rnd256();

        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(cmd_ready), 256'(1));
        chk("rst_outputs", {mem_wdata | mult_data}, '0);
        chk("rst_ctrl", 256'({busy, done, err, mem_req, mem_we, mem_addr, mult_en, mult_rw}), '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            mem[tbl[i].a] = tbl[i].ma;
            mem[tbl[i].b] = tbl[i].mb;
            check_cmd($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].delay, tbl[i].exp);
        end

        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(64, 255));
            b = 8'($urandom_range(64, 255));
            d = 8'($urandom_range(64, 255));
            check_cmd($sformatf("rnd%0d", i), a, b, d, $urandom_range(0, 3), matmul(mem[a], mem[b]));
        end

        check_cmd("perf_delay3", 8'h05, 8'h06, 8'h07, 3, matmul(mem[8'h05], mem[8'h06]));

        // Multiplier never completes after operand B.
        mult_stall = 1'b1;
        wq0 = wr_addr_q.size();
        run_cmd(8'h01, 8'h02, 8'h50, 0, lat, gd, ge);
        chk("tmo_err", 256'(ge), 256'(1));
        chk("tmo_no_done", 256'(gd), '0);
        chk("tmo_latency", 256'(lat), 256'(5 + TIMEOUT));
        chk("tmo_req_low", 256'(mem_req), '0);
        chk("tmo_no_write", 256'(wr_addr_q.size() - wq0), '0);
        @(negedge clk);
        chk("tmo_err_pulse", 256'(err), '0);
        chk("tmo_ready", 256'(cmd_ready), 256'(1));

        // Reset asserted while waiting for the product.
        cmd_src_a = 8'h10; cmd_src_b = 8'h11; cmd_dst = 8'h60; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 256'(cmd_ready), 256'(1));
        chk("midrst_data", {mem_wdata | mult_data}, '0);
        chk("midrst_ctrl", 256'({busy, done, err, mem_req, mem_we, mem_addr, mult_en, mult_rw}), '0);
`ifdef MAT_SEQ_PERF_EN
        chk("midrst_perf", 256'({perf_cycles, perf_cmds}), '0);
        n_ok = 0;
`endif
        rst_n = 1'b1;
        mult_stall = 1'b0;
        wq0 = wr_addr_q.size();
        bad = 1'b0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge clk);
            if (done || err) bad = 1'b1;
        end
        chk("midrst_quiet", 256'(bad), '0);
        chk("midrst_no_write", 256'(wr_addr_q.size() - wq0), '0);
        check_cmd("post_rst", 8'h10, 8'h11, 8'h12, 0, {16{16'h0018}});

        // Two commands with cmd_valid held throughout, slow memory.
        mem_delay = 5;
        e1 = matmul(mem[8'h40], mem[8'h41]);
        e2 = matmul(mem[8'h43], mem[8'h44]);
        wq0 = wr_addr_q.size();
        cmd_src_a = 8'h40; cmd_src_b = 8'h41; cmd_dst = 8'h42; cmd_valid = 1'b1;
        @(negedge clk);
        chk("b2b_busy", 256'(busy), 256'(1));
        cmd_src_a = 8'h43; cmd_src_b = 8'h44; cmd_dst = 8'h45;
        n = 0;
        bad = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (cmd_ready) bad = 1'b1;
        end
        chk("b2b_lat1", 256'(n), 256'(8 + 15));
        chk("b2b_no_early_accept", 256'(bad), '0);
        @(negedge clk);
        chk("b2b_idle_after_done", 256'(cmd_ready), 256'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second_rd", 256'({busy, mem_addr}), 256'({1'b1, 8'h43}));
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat2", 256'(n), 256'(8 + 15));
        chk("b2b_writes", 256'(wr_addr_q.size() - wq0), 256'(2));
        chk("b2b_order", 256'({wr_addr_q[wq0], wr_addr_q[wq0+1]}), 256'({8'h42, 8'h45}));
        chk("b2b_res1", mem[8'h42], e1);
        chk("b2b_res2", mem[8'h45], e2);
        @(negedge clk);
`ifdef MAT_SEQ_PERF_EN
        chk("b2b_perf_cycles", 256'(perf_cycles), 256'(n + 1));
        chk("b2b_perf_cmds", 256'(perf_cmds), 256'(n_ok + 2));
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
